// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer.
// The operands are WORDS 16-bit limbs wide. The limbs are fed LSB-first through
// one shared CLA16, one limb per clock, and a registered carry chains the limbs.
//
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// RUN   | one limb per clock through the CLA16, for WORDS cycles
// DONE  | single-cycle done pulse; a start here is accepted immediately

module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        g,
    output logic        p
);
    logic [15:0] gb, pb, c;
    logic [3:0]  gg, pg, cg;

    assign gb = a & b;
    assign pb = a ^ b;

    // 4-bit group generate/propagate
    always_comb begin
        gg = '0;
        pg = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = gb[4*k+3]
                  | (pb[4*k+3] & gb[4*k+2])
                  | (pb[4*k+3] & pb[4*k+2] & gb[4*k+1])
                  | (pb[4*k+3] & pb[4*k+2] & pb[4*k+1] & gb[4*k]);
            pg[k] = &pb[4*k +: 4];
        end
    end

    // second-level lookahead for the carry into each group
    always_comb begin
        cg[0] = cin;
        cg[1] = gg[0] | (pg[0] & cin);
        cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
        cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & cin);
    end

    // per-bit carries inside each group from its group carry-in
    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = gb[4*k] | (pb[4*k] & cg[k]);
            c[4*k+2] = gb[4*k+1] | (pb[4*k+1] & gb[4*k])
                     | (pb[4*k+1] & pb[4*k] & cg[k]);
            c[4*k+3] = gb[4*k+2] | (pb[4*k+2] & gb[4*k+1])
                     | (pb[4*k+2] & pb[4*k+1] & gb[4*k])
                     | (pb[4*k+2] & pb[4*k+1] & pb[4*k] & cg[k]);
        end
    end

    assign s = pb ^ c;
    assign g = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
             | (pg[3] & pg[2] & pg[1] & gg[0]);
    assign p = &pg;
endmodule

module mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum,
    output logic                cout,
    output logic                ovf
);
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [WORDS-1:0][15:0]  opa, opb, sum_r;
    logic                    carry, msb_a, msb_b;
    logic [IW-1:0]           idx;
    logic [15:0]             limb_s;
    logic                    limb_g, limb_p, last;

    assign last = (idx == IW'(WORDS-1));
    assign sum  = sum_r;

    cla16 u_cla (
        .a   (opa[idx]),
        .b   (opb[idx]),
        .cin (carry),
        .s   (limb_s),
        .g   (limb_g),
        .p   (limb_p)
    );

    // sequencer: accept operands, walk the limbs, then pulse done
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum_r <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            msb_a <= 1'b0;
            msb_b <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // subtraction is A + ~B with the +1 folded into the carry-in
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub;
                        msb_a <= a[16*WORDS-1];
                        msb_b <= sub ? ~b[16*WORDS-1] : b[16*WORDS-1];
                        idx   <= '0;
                        sum_r <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_r[idx] <= limb_s;
                    carry      <= limb_g | (limb_p & carry);
                    if (last) begin
                        cout  <= limb_g | (limb_p & carry);
                        ovf   <= (msb_a == msb_b) & (limb_s[15] != msb_a);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mp_add_seq.sv
// Testbench for mp_add_seq (WORDS=4): scoreboard fed at issue time, popped on done.
module tb_mp_add_seq;
    localparam int WORDS = 4;
    localparam int N     = 16*WORDS;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start, sub;
    logic [N-1:0] a, b, sum;
    logic         busy, done, cout, ovf;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t mon_e;

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // reference: plain wide arithmetic, signed overflow from a sign-extended result
    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
        exp_t e;
        logic [N:0]        u;
        logic signed [N:0] sx;
        if (s) begin
            u      = {1'b0, x} - {1'b0, y};
            e.cout = (x >= y);
            sx     = $signed({x[N-1], x}) - $signed({y[N-1], y});
        end else begin
            u      = {1'b0, x} + {1'b0, y};
            e.cout = u[N];
            sx     = $signed({x[N-1], x}) + $signed({y[N-1], y});
        end
        e.sum = u[N-1:0];
        e.ovf = (sx[N] != sx[N-1]);
        return e;
    endfunction

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_e = sb.pop_front();
                check("sum",  sum,  mon_e.sum);
                check("cout", {63'd0, cout}, {63'd0, mon_e.cout});
                check("ovf",  {63'd0, ovf},  {63'd0, mon_e.ovf});
            end
        end
    end

    // wait (from the current negedge) for done, counting busy cycles on the way
    task automatic wait_done(output int nb, input bit poke);
        bit seen;
        nb   = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nb++;
            start = (poke && i == 1);
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within 12 cycles");
        end
    endtask

    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                          input bit chk_t, input bit poke);
        int nb;
        @(negedge clk);
        start = 1'b1; a = x; b = y; sub = s;
        sb.push_back(model(x, y, s));
        @(negedge clk);
        start = 1'b0;
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        sub = 1'($urandom);
        wait_done(nb, poke);
        if (chk_t) check("busy_cycles", 64'(nb), 64'd4);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_sum",  sum, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        check("rst_ovf",  {63'd0, ovf},  64'd0);

        // directed corner cases
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1, 0);
        run_op(64'd0, 64'd1, 1'b1, 1, 0);
        run_op(64'd5, 64'd5, 1'b1, 1, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1, 1);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1, 1);

        // back-to-back with start held high and operands changed during RUN
        @(negedge clk);
        start = 1'b1; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h8000_0000_0000_0000; sub = 1'b0;
        sb.push_back(model(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0));
        @(negedge clk);
        a = 64'h0001_0000_FFFF_1234; b = 64'h0000_0001_0001_1235; sub = 1'b1;
        sb.push_back(model(64'h0001_0000_FFFF_1234, 64'h0000_0001_0001_1235, 1'b1));
        for (int i = 0; i < 12 && !done; i++) @(negedge clk);
        check("b2b_first_done", {63'd0, done}, 64'd1);
        @(negedge clk);
        start = 1'b0; a = '1; b = '1;
        check("b2b_no_bubble", {63'd0, busy}, 64'd1);
        check("b2b_done_1cyc", {63'd0, done}, 64'd0);
        check("b2b_sum_clr",  sum, 64'd0);
        check("b2b_cout_clr", {63'd0, cout}, 64'd0);
        check("b2b_ovf_clr",  {63'd0, ovf},  64'd0);
        wait_done(nb, 0);
        check("b2b_busy_cycles", 64'(nb), 64'd4);

        // reset two cycles into RUN aborts the operation
        @(negedge clk);
        start = 1'b1; a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; sub = 1'b0;
        sb.push_back(model(a, b, sub));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_sum",  sum, 64'd0);
        check("abort_cout", {63'd0, cout}, 64'd0);
        check("abort_ovf",  {63'd0, ovf},  64'd0);
        sb.delete();
        rst = 1'b0;
        repeat (8) @(negedge clk);
        run_op(64'h0000_0000_0001_FFFF, 64'd1, 1'b0, 1, 0);

        // randomized vectors, biased toward carry chains across limb boundaries
        for (int n = 0; n < 2000; n++) begin
            logic [N-1:0] x, y, mask;
            logic         s;
            int           k;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: begin
                    k    = $urandom_range(1, 3);
                    mask = (64'd1 << (16*k)) - 64'd1;
                    x    = x | mask;
                    y    = 64'd1;
                    s    = 1'b0;
                end
                2: begin
                    y = x + 64'($urandom_range(0, 1));
                    s = 1'b1;
                end
                default: begin
                    x = {x[63], 47'd0, x[15:0]};
                    y = {y[63], 47'd0, y[15:0]};
                end
            endcase
            run_op(x, y, s, (n % 50) == 0, 1'($urandom));
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
